// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_seq_if.sv
// Control/status bundle between a power controller and the fillcap sequencer.
// The master drives the request side; the sequencer (slave) drives the enable bus and status.
interface gf180mcu_fd_sc_mcu9t5v0__fillcap_seq_if #(
  parameter int SEGMENTS = 16,
  parameter int DW       = 8,
  parameter int CW       = 7
);
  logic                REQ;
  logic [DW-1:0]       DWELL;
  logic                HOLD;
  logic [SEGMENTS-1:0] EN;
  logic [CW-1:0]       LEVEL;
  logic                BUSY;
  logic                ACK;

  modport master (
    output REQ, DWELL, HOLD,
    input  EN, LEVEL, BUSY, ACK
  );

  modport slave (
    input  REQ, DWELL, HOLD,
    output EN, LEVEL, BUSY, ACK
  );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_seq.sv
// Decap segment sequencer: ramps a thermometer enable bus one segment per dwell period
// toward the level requested by REQ, with freeze (HOLD) and mid-ramp reversal.
module gf180mcu_fd_sc_mcu9t5v0__fillcap_seq #(
  parameter int SEGMENTS = 16,
  parameter int DW       = 8,
  parameter int CW       = 7
) (
  input logic CLK,
  input logic RST,
  gf180mcu_fd_sc_mcu9t5v0__fillcap_seq_if.slave bus
);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [CW-1:0] SEG_MAX = CW'(SEGMENTS);

  state_t              state_r, state_s;
  logic [CW-1:0]       level_r, level_s;
  logic [DW-1:0]       cnt_r, cnt_s;
  logic                pend_r, pend_s;
  logic                ack_r, ack_s;
  logic                busy_r;
  logic [SEGMENTS-1:0] en_r;
  logic [DW-1:0]       reload_s;
  logic                going_up_s;

  function automatic logic [SEGMENTS-1:0] therm(input logic [CW-1:0] lvl);
    logic [SEGMENTS-1:0] t;
    t = {SEGMENTS{1'b0}};
    for (int i = 0; i < SEGMENTS; i++) begin
      t[i] = (CW'(i) < lvl);
    end
    return t;
  endfunction

  // Dwell reload value; a programmed dwell of zero behaves as one cycle
  always_comb begin
    if (bus.DWELL == {DW{1'b0}}) begin
      reload_s = {DW{1'b0}};
    end else begin
      reload_s = bus.DWELL - DW'(1);
    end
  end

  // Next-state and step logic
  always_comb begin
    state_s    = state_r;
    level_s    = level_r;
    cnt_s      = cnt_r;
    pend_s     = pend_r;
    ack_s      = 1'b0;
    going_up_s = (state_r == RAMP_UP);
    case (state_r)
      OFF: begin
        if (bus.REQ) begin
          state_s = RAMP_UP;
          level_s = CW'(1);
          cnt_s   = reload_s;
          pend_s  = 1'b0;
        end else begin
          state_s = OFF;
        end
      end
      ON: begin
        if (!bus.REQ) begin
          state_s = RAMP_DOWN;
          level_s = level_r - CW'(1);
          cnt_s   = reload_s;
          pend_s  = 1'b0;
        end else begin
          state_s = ON;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (bus.REQ != going_up_s) begin
          // Reversal never moves LEVEL; under HOLD the reload waits for release
          state_s = bus.REQ ? RAMP_UP : RAMP_DOWN;
          if (bus.HOLD) begin
            pend_s = 1'b1;
          end else begin
            cnt_s  = reload_s;
            pend_s = 1'b0;
          end
        end else if (bus.HOLD) begin
          state_s = state_r;
        end else if (pend_r) begin
          cnt_s  = reload_s;
          pend_s = 1'b0;
        end else if (cnt_r == {DW{1'b0}}) begin
          cnt_s = reload_s;
          if (going_up_s && (level_r < SEG_MAX)) begin
            level_s = level_r + CW'(1);
            if (level_r + CW'(1) == SEG_MAX) begin
              state_s = ON;
              ack_s   = 1'b1;
            end else begin
              state_s = RAMP_UP;
            end
          end else if (!going_up_s && (level_r != {CW{1'b0}})) begin
            level_s = level_r - CW'(1);
            if (level_r == CW'(1)) begin
              state_s = OFF;
              ack_s   = 1'b1;
            end else begin
              state_s = RAMP_DOWN;
            end
          end else begin
            state_s = state_r;
          end
        end else begin
          cnt_s = cnt_r - DW'(1);
        end
      end
      default: begin
        state_s = OFF;
        level_s = {CW{1'b0}};
        cnt_s   = {DW{1'b0}};
        pend_s  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset collapses all enables in one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= OFF;
      level_r <= {CW{1'b0}};
      cnt_r   <= {DW{1'b0}};
      pend_r  <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      en_r    <= {SEGMENTS{1'b0}};
    end else begin
      state_r <= state_s;
      level_r <= level_s;
      cnt_r   <= cnt_s;
      pend_r  <= pend_s;
      ack_r   <= ack_s;
      busy_r  <= (state_s == RAMP_UP) || (state_s == RAMP_DOWN);
      en_r    <= therm(level_s);
    end
  end

  assign bus.EN    = en_r;
  assign bus.LEVEL = level_r;
  assign bus.BUSY  = busy_r;
  assign bus.ACK   = ack_r;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_seq.sv
// Self-checking bench for the fillcap sequencer: directed scenarios plus a randomized
// run against a behavioural level/direction/wait model.
module tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_seq;
  localparam int S  = 16;
  localparam int DW = 8;
  localparam int CW = 7;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__fillcap_seq_if #(.SEGMENTS(S), .DW(DW), .CW(CW)) bus ();

  gf180mcu_fd_sc_mcu9t5v0__fillcap_seq #(.SEGMENTS(S), .DW(DW), .CW(CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // behavioural model: level, direction (+1/-1/0 idle), cycles left before next step
  int m_lvl  = 0;
  int m_dir  = 0;
  int m_wait = 0;
  bit m_pend = 1'b0;
  bit m_ack  = 1'b0;

  function automatic logic [S-1:0] exp_en(input int l);
    logic [63:0] t;
    t = (64'd1 << l) - 64'd1;
    return t[S-1:0];
  endfunction

  task automatic model_step();
    int d;
    int want;
    d = (bus.DWELL == 0) ? 1 : int'(bus.DWELL);
    m_ack = 1'b0;
    if (RST) begin
      m_lvl = 0; m_dir = 0; m_wait = 0; m_pend = 1'b0;
    end else if (m_dir == 0) begin
      if (bus.REQ && m_lvl == 0) begin
        m_dir = 1; m_lvl = 1; m_wait = d - 1; m_pend = 1'b0;
      end else if (!bus.REQ && m_lvl == S) begin
        m_dir = -1; m_lvl = S - 1; m_wait = d - 1; m_pend = 1'b0;
      end
    end else begin
      want = bus.REQ ? 1 : -1;
      if (want != m_dir) begin
        m_dir = want;
        if (bus.HOLD) m_pend = 1'b1;
        else begin m_wait = d - 1; m_pend = 1'b0; end
      end else if (bus.HOLD) begin
        m_wait = m_wait;
      end else if (m_pend) begin
        m_wait = d - 1; m_pend = 1'b0;
      end else if (m_wait == 0) begin
        m_lvl += m_dir;
        m_wait = d - 1;
        if (m_lvl == S || m_lvl == 0) begin m_dir = 0; m_ack = 1'b1; end
      end else begin
        m_wait--;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.REQ = 1'b0; bus.DWELL = 8'd0; bus.HOLD = 1'b0;
    tick(); tick();
    total++; if (bus.LEVEL !== 7'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.LEVEL); end
    total++; if (bus.EN !== 16'd0) begin bad++; $display("FAIL reset_en got=%h exp=0", bus.EN); end
    total++; if (bus.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
    total++; if (bus.ACK !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.ACK); end
  endtask

  task automatic test_ramp_up();
    int e;
    RST = 1'b0; bus.REQ = 1'b1; bus.DWELL = 8'd3; bus.HOLD = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      tick();
      e = 1 + (c - 1) / 3;
      total++; if (bus.LEVEL !== CW'(e)) begin bad++; $display("FAIL up_level cyc=%0d got=%0d exp=%0d", c, bus.LEVEL, e); end
      total++; if (bus.EN !== exp_en(e)) begin bad++; $display("FAIL up_en cyc=%0d got=%h exp=%h", c, bus.EN, exp_en(e)); end
      total++; if (bus.ACK !== (c == 46)) begin bad++; $display("FAIL up_ack cyc=%0d got=%b exp=%b", c, bus.ACK, c == 46); end
      total++; if (bus.BUSY !== (c < 46)) begin bad++; $display("FAIL up_busy cyc=%0d got=%b exp=%b", c, bus.BUSY, c < 46); end
    end
    bus.HOLD = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (bus.LEVEL !== 7'd16 || bus.ACK !== 1'b0 || bus.BUSY !== 1'b0) begin
        bad++; $display("FAIL on_idle got=%0d/%b/%b exp=16/0/0", bus.LEVEL, bus.ACK, bus.BUSY);
      end
    end
    bus.HOLD = 1'b0;
  endtask

  task automatic test_ramp_down_dwell0();
    bus.REQ = 1'b0; bus.DWELL = 8'd0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      total++; if (bus.LEVEL !== CW'(16 - c)) begin bad++; $display("FAIL down_level cyc=%0d got=%0d exp=%0d", c, bus.LEVEL, 16 - c); end
      total++; if (bus.ACK !== (c == 16)) begin bad++; $display("FAIL down_ack cyc=%0d got=%b exp=%b", c, bus.ACK, c == 16); end
      total++; if (bus.BUSY !== (c < 16)) begin bad++; $display("FAIL down_busy cyc=%0d got=%b exp=%b", c, bus.BUSY, c < 16); end
    end
  endtask

  task automatic test_reversal();
    bus.REQ = 1'b1; bus.DWELL = 8'd2;
    for (int c = 1; c <= 9; c++) tick();
    total++; if (bus.LEVEL !== 7'd5) begin bad++; $display("FAIL rev_pre got=%0d exp=5", bus.LEVEL); end
    bus.REQ = 1'b0;
    tick();
    total++; if (bus.LEVEL !== 7'd5 || bus.ACK !== 1'b0 || bus.BUSY !== 1'b1) begin
      bad++; $display("FAIL rev_edge got=%0d/%b/%b exp=5/0/1", bus.LEVEL, bus.ACK, bus.BUSY);
    end
    for (int j = 1; j <= 5; j++) begin
      tick();
      total++; if (bus.LEVEL !== CW'(6 - j) || bus.ACK !== 1'b0) begin
        bad++; $display("FAIL rev_gap j=%0d got=%0d/%b exp=%0d/0", j, bus.LEVEL, bus.ACK, 6 - j);
      end
      tick();
      total++; if (bus.LEVEL !== CW'(5 - j) || bus.ACK !== (j == 5)) begin
        bad++; $display("FAIL rev_step j=%0d got=%0d/%b exp=%0d/%b", j, bus.LEVEL, bus.ACK, 5 - j, j == 5);
      end
    end
  endtask

  task automatic test_hold();
    bus.REQ = 1'b1; bus.DWELL = 8'd3;
    for (int c = 1; c <= 20; c++) tick();
    total++; if (bus.LEVEL !== 7'd7) begin bad++; $display("FAIL hold_pre got=%0d exp=7", bus.LEVEL); end
    bus.HOLD = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (bus.LEVEL !== 7'd7 || bus.BUSY !== 1'b1) begin
        bad++; $display("FAIL hold_frozen c=%0d got=%0d/%b exp=7/1", c, bus.LEVEL, bus.BUSY);
      end
    end
    bus.HOLD = 1'b0;
    tick();
    total++; if (bus.LEVEL !== 7'd7) begin bad++; $display("FAIL hold_resume1 got=%0d exp=7", bus.LEVEL); end
    tick();
    total++; if (bus.LEVEL !== 7'd8) begin bad++; $display("FAIL hold_resume2 got=%0d exp=8", bus.LEVEL); end
  endtask

  task automatic test_reset_mid_ramp();
    RST = 1'b1; tick();
    RST = 1'b0; bus.REQ = 1'b1; bus.DWELL = 8'd1;
    for (int c = 1; c <= 9; c++) tick();
    total++; if (bus.LEVEL !== 7'd9) begin bad++; $display("FAIL rst_pre got=%0d exp=9", bus.LEVEL); end
    RST = 1'b1;
    tick();
    total++; if (bus.LEVEL !== 7'd0 || bus.EN !== 16'd0 || bus.BUSY !== 1'b0 || bus.ACK !== 1'b0) begin
      bad++; $display("FAIL rst_mid got=%0d/%h/%b/%b exp=0/0/0/0", bus.LEVEL, bus.EN, bus.BUSY, bus.ACK);
    end
    RST = 1'b0;
    tick();
    total++; if (bus.LEVEL !== 7'd1 || bus.EN !== 16'h0001 || bus.BUSY !== 1'b1) begin
      bad++; $display("FAIL rst_restart got=%0d/%h/%b exp=1/0001/1", bus.LEVEL, bus.EN, bus.BUSY);
    end
  endtask

  task automatic test_random();
    int prev;
    int diff;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.REQ = ~bus.REQ;
      bus.HOLD  = ($urandom_range(0, 7) == 0);
      bus.DWELL = DW'($urandom_range(0, 3));
      RST       = ($urandom_range(0, 499) == 0);
      prev = int'(bus.LEVEL);
      tick();
      total++; if (bus.LEVEL !== CW'(m_lvl)) begin bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, bus.LEVEL, m_lvl); end
      total++; if (bus.EN !== exp_en(m_lvl)) begin bad++; $display("FAIL rnd_en c=%0d got=%h exp=%h", c, bus.EN, exp_en(m_lvl)); end
      total++; if (bus.BUSY !== (m_dir != 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, bus.BUSY, m_dir != 0); end
      total++; if (bus.ACK !== m_ack) begin bad++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, bus.ACK, m_ack); end
      total++; if (bus.EN !== exp_en(int'(bus.LEVEL))) begin bad++; $display("FAIL rnd_therm c=%0d en=%h level=%0d", c, bus.EN, bus.LEVEL); end
      diff = int'(bus.LEVEL) - prev;
      if (!RST) begin
        total++; if (diff > 1 || diff < -1) begin bad++; $display("FAIL rnd_delta c=%0d got=%0d exp=<=1", c, diff); end
      end
      if (bus.ACK === 1'b1) begin
        total++; if (bus.LEVEL !== 7'd0 && bus.LEVEL !== 7'd16) begin bad++; $display("FAIL rnd_ack_level c=%0d got=%0d exp=0or16", c, bus.LEVEL); end
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down_dwell0();
    test_reversal();
    test_hold();
    test_reset_mid_ramp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__fillcap_seq.md
Name: gf180mcu_fd_sc_mcu9t5v0__fillcap_seq

Overview:
- Parametrised sequencer for a bank of switchable fillcap (decap) segments.
- Turns segments on and off one at a time, so rail inrush current and discharge current stay bounded.
- Sits beside a power-domain switch. The power controller requests full decap on or off, and this block produces a thermometer-coded enable bus for the segment switches.
- Extends the fixed fillcap_16 cell in three ways: segment count is configurable, ramp dwell is programmable, and it supports reversal mid-ramp.

Parameters:
- SEGMENTS, 16: number of switchable decap segments (width of EN). Legal range 2..64.
- DW, 8: width of the DWELL input and of the internal dwell counter.
- CW, 7: width of the segment-count output LEVEL. Must satisfy 2^CW > SEGMENTS.

Ports:
- CLK  input  1  Single clock. All state updates on its rising edge.
- RST  input  1  Synchronous reset, active-high. Sampled on the CLK rising edge.
- REQ  input  1  Level request: 1 = all segments on, 0 = all segments off.
- DWELL  input  DW  Cycles between successive segment steps. A value of 0 is treated as 1. Sampled at the start of each step.
- HOLD  input  1  Freeze: while 1, the dwell counter and LEVEL do not advance. The FSM may still reverse direction.
- EN  output  SEGMENTS  Thermometer enable bus. Bit i is 1 iff i < LEVEL.
- LEVEL  output  CW  Number of segments currently enabled, 0..SEGMENTS.
- BUSY  output  1  1 while in RAMP_UP or RAMP_DOWN.
- ACK  output  1  One-cycle pulse when LEVEL reaches the target set by REQ.

Behaviour:
- Reset: when RST=1 at a rising CLK edge, the next state is:
  - state OFF, LEVEL=0, EN=0, BUSY=0, ACK=0;
  - dwell counter = 0.
- RST has priority over all other inputs. Asserting RST mid-ramp drops all enables in one cycle. This is intentional: reset means the domain is collapsing.
- States: OFF, RAMP_UP, ON, RAMP_DOWN. All outputs are registered.
- OFF (LEVEL=0):
  - REQ=1 → RAMP_UP. Load the dwell counter with max(DWELL,1)-1.
  - The first segment turns on the same edge the FSM enters RAMP_UP. So LEVEL=1 one cycle after REQ is sampled high.
- RAMP_UP:
  - If HOLD=1, nothing advances.
  - Otherwise, when the dwell counter is 0 and LEVEL<SEGMENTS: LEVEL increments by 1 and the counter reloads with max(DWELL,1)-1.
  - Otherwise, the counter decrements by 1.
  - When the step takes LEVEL to SEGMENTS: go to ON, and assert ACK for exactly one cycle, aligned with the first cycle of LEVEL=SEGMENTS.
- ON (LEVEL=SEGMENTS): REQ=0 → RAMP_DOWN. The first segment is removed on the entry edge, mirroring RAMP_UP.
- RAMP_DOWN:
  - Same step rule as RAMP_UP, but LEVEL decrements.
  - When LEVEL reaches 0: go to OFF, with a one-cycle ACK.
- Reversal:
  - REQ falling during RAMP_UP → RAMP_DOWN on the next edge, without changing LEVEL on that edge.
  - REQ rising during RAMP_DOWN → RAMP_UP, likewise.
  - In both cases the dwell counter reloads with max(DWELL,1)-1, so spacing from the last step is at least one full dwell.
  - No ACK is issued on reversal.
- Step timing:
  - Step spacing is exactly max(DWELL,1) cycles when HOLD=0.
  - Total ramp length with constant DWELL=D: 1 + (SEGMENTS-1)*max(D,1) cycles from the REQ edge to ACK.
- HOLD:
  - HOLD=1 in OFF or ON has no effect.
  - HOLD=1 with a simultaneous REQ reversal: the direction change still happens; the counter reload is deferred until HOLD=0.
- Invariants:
  - LEVEL never exceeds SEGMENTS and never wraps below 0.
  - EN always equals the thermometer code of LEVEL.
  - LEVEL changes by at most 1 per cycle.
- Width rules:
  - Dwell arithmetic is unsigned DW-bit with no overflow; reload occurs before any decrement past 0.
  - LEVEL is unsigned CW-bit.

Test Plan:
- Reset then REQ=1, DWELL=3, SEGMENTS=16 → LEVEL reads 1 at cycle 1 and reaches 16 at cycle 46; ACK high only at cycle 46; BUSY high at cycles 1..45.
- From ON, REQ=0, DWELL=0 → LEVEL decrements every cycle, 15..0; ACK pulses when LEVEL=0; state is OFF.
- REQ=1, DWELL=2, then REQ=0 while LEVEL=5 → LEVEL holds at 5 for the reversal cycle, then falls 4,3,2,1,0 at 2-cycle spacing; no ACK at reversal; one ACK at 0.
- RAMP_UP at LEVEL=7, HOLD=1 for 10 cycles → LEVEL stays 7 and the counter is frozen; after HOLD=0 the ramp resumes with the remaining dwell.
- RST=1 mid-ramp at LEVEL=9 → next cycle LEVEL=0, EN=0, BUSY=0, ACK=0, state OFF even with REQ=1; ramp restarts on the first cycle RST=0.
- Random REQ/HOLD/DWELL for 10k cycles → EN always equals the thermometer code of LEVEL; |ΔLEVEL| ≤ 1 per cycle; ACK only at LEVEL = 0 or SEGMENTS.
